// File: rtl/fp8_add_arbiter.sv
// Round-robin sequencer sharing one combinational FP8 (E5M2) adder among NUM_REQ
// requesters: grant in IDLE, add in EXEC, hold the tagged result in RESP.

module fp_add #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o
);

  // Significand layout: hidden bit, mantissa, then guard/round/sticky.
  localparam int SW     = MAN_WIDTH + 4;
  localparam int EMAX_I = (1 << EXP_WIDTH) - 1;
  localparam logic [EXP_WIDTH-1:0] EMAX = '1;

  logic                 sa, sb, bs, ss;
  logic [EXP_WIDTH-1:0] ea, eb, be, se, be_eff, se_eff;
  logic [MAN_WIDTH-1:0] ma, mb, bm, sm;
  logic                 a_nan, b_nan, a_inf, b_inf, eff_sub;
  logic [SW-1:0]        big_sig, small_sig, small_al, norm;
  logic [2*SW-1:0]      small_ext;
  logic [SW:0]          sum_raw;
  logic [MAN_WIDTH:0]   keep;
  logic [MAN_WIDTH+1:0] rnd;
  logic                 round_up, hidden, res_sign;
  logic [MAN_WIDTH-1:0] mant;
  int                   shamt, e;

  assign sa    = a_i[WIDTH-1];
  assign sb    = b_i[WIDTH-1] ^ sub_i;
  assign ea    = a_i[WIDTH-2 -: EXP_WIDTH];
  assign eb    = b_i[WIDTH-2 -: EXP_WIDTH];
  assign ma    = a_i[MAN_WIDTH-1:0];
  assign mb    = b_i[MAN_WIDTH-1:0];
  assign a_nan = (ea == EMAX) && (ma != '0);
  assign b_nan = (eb == EMAX) && (mb != '0);
  assign a_inf = (ea == EMAX) && (ma == '0);
  assign b_inf = (eb == EMAX) && (mb == '0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    bs = sa; be = ea; bm = ma;
    ss = sb; se = eb; sm = mb;
    if (a_i[WIDTH-2:0] < b_i[WIDTH-2:0]) begin
      bs = sb; be = eb; bm = mb;
      ss = sa; se = ea; sm = ma;
    end
    be_eff    = (be == '0) ? EXP_WIDTH'(1) : be;
    se_eff    = (se == '0) ? EXP_WIDTH'(1) : se;
    big_sig   = {be != '0, bm, 3'b000};
    small_sig = {se != '0, sm, 3'b000};
    shamt     = int'(be_eff) - int'(se_eff);
    if (shamt > SW + 1) shamt = SW + 1;
    small_ext = {small_sig, {SW{1'b0}}} >> shamt;
    small_al  = small_ext[2*SW-1:SW] | {{(SW-1){1'b0}}, |small_ext[SW-1:0]};
    eff_sub   = bs ^ ss;
    sum_raw   = eff_sub ? ({1'b0, big_sig} - {1'b0, small_al})
                        : ({1'b0, big_sig} + {1'b0, small_al});

    e = int'(be_eff);
    if (sum_raw[SW]) begin
      norm = {sum_raw[SW:2], sum_raw[1] | sum_raw[0]};
      e    = e + 1;
    end else begin
      norm = sum_raw[SW-1:0];
      // Left-normalise, but never below the subnormal exponent.
      for (int i = 0; i < SW; i++) begin
        if (!norm[SW-1] && e > 1) begin
          norm = norm << 1;
          e    = e - 1;
        end
      end
    end

    keep     = norm[SW-1:3];
    round_up = norm[2] & (norm[1] | norm[0] | keep[0]);
    rnd      = {1'b0, keep} + (MAN_WIDTH+2)'(round_up);
    if (rnd[MAN_WIDTH+1]) begin
      e      = e + 1;
      hidden = 1'b1;
      mant   = '0;
    end else begin
      hidden = rnd[MAN_WIDTH];
      mant   = rnd[MAN_WIDTH-1:0];
    end
    res_sign = (eff_sub && sum_raw == '0) ? 1'b0 : bs;

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      sum_o = {1'b0, EMAX, 1'b1, {(MAN_WIDTH-1){1'b0}}};
    else if (a_inf)
      sum_o = {sa, EMAX, {MAN_WIDTH{1'b0}}};
    else if (b_inf)
      sum_o = {sb, EMAX, {MAN_WIDTH{1'b0}}};
    else if (e >= EMAX_I)
      sum_o = {res_sign, EMAX, {MAN_WIDTH{1'b0}}};
    else
      sum_o = {res_sign, hidden ? EXP_WIDTH'(e) : {EXP_WIDTH{1'b0}}, mant};
  end

endmodule

module fp8_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_sum,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic            op_sub_q, op_sub_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [7:0]      add_sum;
  int              idx;

  // Search starts one past the last winner, so each winner drops to lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found && !rst) req_ready[grant_idx] = 1'b1;
  end

  fp_add #(
    .WIDTH    (8),
    .EXP_WIDTH(5),
    .MAN_WIDTH(2)
  ) u_fp_add (
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .sub_i(op_sub_q),
    .sum_o(add_sum)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sub_d    = op_sub_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_a_d   = req_a[8*grant_idx +: 8];
          op_b_d   = req_b[8*grant_idx +: 8];
          op_sub_d = req_sub[grant_idx];
          op_id_d  = grant_idx;
          last_d   = grant_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use <= so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sub_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sub_q    <= op_sub_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// Directed bench for fp8_add_arbiter: table of single ops with hand-computed
// E5M2 sums, plus sequences for round-robin, backpressure, mid-op reset and idle.

module tb_fp8_add_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [7:0]     rsp_sum;
  logic [1:0]     rsp_id;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
  } vec_t;

  vec_t vecs[10];

  fp8_add_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_sub  (req_sub),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
  endtask

  task automatic set_lane(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_sub[id]      = sub;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_req();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One op end to end: grant cycle, EXEC cycle, RESP cycle, back in IDLE.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    rsp_ready = 1'b1;
    clear_req();
    req_valid[v.id] = 1'b1;
    set_lane(int'(v.id), v.a, v.b, v.sub);
    #1;
    check({v.name, "_grant"}, 32'(req_ready), 32'(1) << v.id);
    check({v.name, "_idle_busy"}, 32'(busy), 0);
    @(negedge clk);
    clear_req();
    #1;
    check({v.name, "_exec_busy"}, 32'(busy), 1);
    check({v.name, "_exec_ready"}, 32'(req_ready), 0);
    check({v.name, "_exec_valid"}, 32'(rsp_valid), 0);
    @(negedge clk);
    #1;
    check({v.name, "_rsp_valid"}, 32'(rsp_valid), 1);
    check({v.name, "_rsp_sum"}, 32'(rsp_sum), 32'(v.sum));
    check({v.name, "_rsp_id"}, 32'(rsp_id), 32'(v.id));
    @(negedge clk);
    #1;
    check({v.name, "_done_busy"}, 32'(busy), 0);
    check({v.name, "_done_valid"}, 32'(rsp_valid), 0);
    check({v.name, "_sum_kept"}, 32'(rsp_sum), 32'(v.sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"one_plus_one",   2'd0, 8'h3C, 8'h3C, 1'b0, 8'h40};
    vecs[1] = '{"sub_1p5_0p5",    2'd2, 8'h3E, 8'h38, 1'b1, 8'h3C};
    vecs[2] = '{"add_1p5_0p5",    2'd2, 8'h3E, 8'h38, 1'b0, 8'h40};
    vecs[3] = '{"two_plus_one",   2'd1, 8'h40, 8'h3C, 1'b0, 8'h42};
    vecs[4] = '{"one_minus_two",  2'd3, 8'h3C, 8'h40, 1'b1, 8'hBC};
    vecs[5] = '{"cancel_to_zero", 2'd1, 8'h3C, 8'h3C, 1'b1, 8'h00};
    vecs[6] = '{"max_overflow",   2'd0, 8'h7B, 8'h7B, 1'b0, 8'h7C};
    vecs[7] = '{"subnormals",     2'd3, 8'h01, 8'h01, 1'b0, 8'h02};
    vecs[8] = '{"tie_to_even_dn", 2'd0, 8'h3C, 8'h30, 1'b0, 8'h3C};
    vecs[9] = '{"tie_to_even_up", 2'd2, 8'h3D, 8'h30, 1'b0, 8'h3E};

    rst       = 1'b1;
    rsp_ready = 1'b0;
    clear_req();
    req_valid = '1;

    // Reset state, including req_ready held low while rst is high.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_sum", 32'(rsp_sum), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_req();

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Idle: nothing requested for 10 cycles.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle_ready_c%0d", c), 32'(req_ready), 0);
      check($sformatf("idle_valid_c%0d", c), 32'(rsp_valid), 0);
      check($sformatf("idle_busy_c%0d", c), 32'(busy), 0);
    end

    // Round-robin: all requesters valid, consumer always ready.
    begin
      int grants[$];
      int gcyc[$];
      int rids[$];
      do_reset();
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int i = 0; i < N; i++) set_lane(i, 8'h3C, 8'h3C, 1'b0);
      for (int c = 0; c < 40 && grants.size() < 5; c++) begin
        #1;
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            grants.push_back(i);
            gcyc.push_back(c);
          end
        end
        if (rsp_valid) rids.push_back(int'(rsp_id));
        @(negedge clk);
      end
      check("rr_grant_count", 32'(grants.size()), 5);
      for (int i = 0; i < grants.size(); i++) begin
        check($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % N));
        if (i > 0) check($sformatf("rr_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 3);
      end
      check("rr_rsp_count", 32'(rids.size() >= 4), 1);
      for (int i = 0; i < rids.size() && i < 4; i++)
        check($sformatf("rr_rsp_id%0d", i), 32'(rids[i]), 32'(i));
      clear_req();
      repeat (4) @(negedge clk);
    end

    // Backpressure: result held for 5 cycles, then the pending requester is granted.
    do_reset();
    @(negedge clk);
    rsp_ready    = 1'b0;
    req_valid[1] = 1'b1;
    set_lane(1, 8'h40, 8'h3C, 1'b0);
    @(negedge clk);
    clear_req();
    @(negedge clk);
    req_valid[2] = 1'b1;
    set_lane(2, 8'h3E, 8'h38, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_valid_c%0d", k), 32'(rsp_valid), 1);
      check($sformatf("bp_sum_c%0d", k), 32'(rsp_sum), 32'h42);
      check($sformatf("bp_id_c%0d", k), 32'(rsp_id), 1);
      check($sformatf("bp_ready_c%0d", k), 32'(req_ready), 0);
      check($sformatf("bp_busy_c%0d", k), 32'(busy), 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(rsp_valid), 1);
    @(negedge clk);
    #1;
    check("bp_idle_busy", 32'(busy), 0);
    check("bp_idle_valid", 32'(rsp_valid), 0);
    check("bp_idle_sum_kept", 32'(rsp_sum), 32'h42);
    check("bp_idle_id_kept", 32'(rsp_id), 1);
    check("bp_next_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    clear_req();
    @(negedge clk);
    #1;
    check("bp_next_valid", 32'(rsp_valid), 1);
    check("bp_next_sum", 32'(rsp_sum), 32'h3C);
    check("bp_next_id", 32'(rsp_id), 2);

    // Reset in EXEC aborts the op and restores requester 0 as top priority.
    do_reset();
    @(negedge clk);
    rsp_ready    = 1'b1;
    req_valid[0] = 1'b1;
    set_lane(0, 8'h3C, 8'h3C, 1'b0);
    @(negedge clk);
    clear_req();
    rst = 1'b1;
    #1;
    check("mid_exec_busy", 32'(busy), 1);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0011;
    set_lane(0, 8'h3C, 8'h3C, 1'b0);
    set_lane(1, 8'h40, 8'h3C, 1'b0);
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    clear_req();
    #1;
    check("mid_no_stale_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    #1;
    check("mid_new_valid", 32'(rsp_valid), 1);
    check("mid_new_id", 32'(rsp_id), 0);
    check("mid_new_sum", 32'(rsp_sum), 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp8_add_arbiter.md
Name: fp8_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fp_add instance (WIDTH=8, EXP_WIDTH=5, MAN_WIDTH=2) among NUM_REQ requesters.
- Each requester presents an operand pair plus a subtract flag on a valid/ready handshake.
- The block registers the winner's operands, drives the shared adder, registers the sum and returns it on a single response channel, tagged with the requester index.
- It sits between several FP8 producers and the one adder datapath on the tile.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index tag.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*8  operand A per requester; requester i uses bits [8i+7:8i].
- req_b  in  NUM_REQ*8  operand B per requester; same slicing as req_a.
- req_sub  in  NUM_REQ  per-requester op select: 0 = a+b, 1 = a-b; drives the fp_add subtract input.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_sum  out  8  FP8 E5M2 result.
- rsp_id  out  ID_W  index of the requester that owns rsp_sum.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. On the rst cycle:
  - state goes to IDLE.
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0, busy = 0, req_ready = 0.
  - Round-robin pointer set so requester 0 has highest priority.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational.
  - Among the set bits of req_valid, pick the first index at or after (last_grant+1) mod NUM_REQ. Drive only that bit of req_ready high.
  - If no req_valid bit is set, req_ready = 0 and state stays IDLE.
  - On a handshake (req_valid[i] & req_ready[i]): capture a_i, b_i, sub_i and id=i into operand registers; set last_grant = i; go to EXEC.
- EXEC (exactly one cycle):
  - The fp_add inputs come from the operand registers only; the adder is combinational.
  - Capture the adder output into rsp_sum and the stored id into rsp_id; set rsp_valid = 1; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_sum and rsp_id are held stable.
  - When rsp_ready = 1: clear rsp_valid and go to IDLE the next cycle.
  - rsp_sum and rsp_id keep their last values after the clear.
- Latency: handshake in cycle T gives rsp_valid high from cycle T+2. With rsp_ready tied high, the next grant happens at T+3 at the earliest (one op per 3 cycles).
- req_ready is 0 in EXEC and RESP. Only one op is ever in flight.
- Requesters must hold valid and operands stable until accepted. A requester that drops valid before grant is not served and no state changes.
- The arbiter never starves a requester: any continuously valid requester is granted within NUM_REQ grants.
- Reset asserted in EXEC or RESP aborts the op: no response is produced and the pointer resets.
- The arbiter adds no rounding, flags or special-case handling. NaN, Inf and subnormal handling is whatever fp_add produces.

Test Plan:
- Single op: req0 a=0x3C (1.0), b=0x3C, sub=0 at T -> rsp_valid at T+2 with rsp_sum=0x40 (2.0), rsp_id=0; req_ready[0] high only in cycle T.
- Subtract: req2 a=0x3E (1.5), b=0x38 (0.5), sub=1 -> rsp_sum=0x3C (1.0), rsp_id=2. Add variant (sub=0) -> 0x40.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; grants 3 cycles apart; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_sum and rsp_id held constant, req_ready stays 0, busy=1. Raise rsp_ready -> IDLE next cycle and the next grant follows.
- Reset mid-op: assert rst in EXEC -> next cycle rsp_valid=0, busy=0; the following grant with req0 and req1 both valid goes to req0.
- Idle: no req_valid for 10 cycles -> req_ready=0, rsp_valid=0, busy=0 throughout.
